// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: error-capture record and error-arbiter state encoding.
package rv_iopmp_pkg;

  localparam int unsigned ERR_ARB_ACK_TIMEOUT = 15;

  typedef struct packed {
    logic [1:0]  ttype;
    logic [2:0]  etype;
    logic [15:0] rrid;
    logic [15:0] eid;
    logic [31:0] addr;
    logic [31:0] addrh;
  } error_capture_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_SET,
    WAIT_CLR
  } err_arb_state_e;

endpackage

// File: rtl/rv_iopmp_rr_arb.sv
// Combinational rotating-priority search: first set request at or after ptr, wrapping.
module rv_iopmp_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = IDX_W'((32'(ptr) + i) % N);
      if (!any_gnt && req[w_idx]) begin
        any_gnt = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_err_arbiter.sv
// Serializes buffered per-instance error records into the single error-capture
// register set, one record in flight until software clears err_reqinfo.ip.
module rv_iopmp_err_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUMBER_IOPMP_INSTANCES = 4,
  parameter int unsigned ACK_TIMEOUT            = ERR_ARB_ACK_TIMEOUT
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        enable_i,
  input  logic [NUMBER_IOPMP_INSTANCES-1:0]           err_valid_i,
  output logic [NUMBER_IOPMP_INSTANCES-1:0]           err_ready_o,
  input  error_capture_t [NUMBER_IOPMP_INSTANCES-1:0] err_i,
  input  logic                                        capture_ip_i,
  output logic                                        err_valid_o,
  output error_capture_t                              err_o,
  output logic                                        ack_timeout_o,
  output logic [$clog2(NUMBER_IOPMP_INSTANCES+1)-1:0] pending_o
);

  localparam int unsigned N      = NUMBER_IOPMP_INSTANCES;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PEND_W = $clog2(N + 1);

  err_arb_state_e   r_state;
  logic [N-1:0]     r_buf_valid;
  error_capture_t   r_buf [N];
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_valid;
  error_capture_t   r_err;
  logic             r_ack_timeout;

  logic [N-1:0]      w_accept;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_any_gnt;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [PEND_W-1:0] w_pending;

  assign err_ready_o   = {N{enable_i}} & ~r_buf_valid;
  assign w_accept      = err_valid_i & err_ready_o;
  assign w_ptr_nxt     = (r_sel == IDX_W'(N - 1)) ? '0 : r_sel + IDX_W'(1);
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign err_valid_o   = r_err_valid;
  assign err_o         = r_err;
  assign ack_timeout_o = r_ack_timeout;
  assign pending_o     = w_pending;

  rv_iopmp_rr_arb #(.N(N)) u_rr_arb (
    .req     (r_buf_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any_gnt)
  );

  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pending = w_pending + PEND_W'(r_buf_valid[i]);
    end
  end

  // Record payloads only need capturing; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (w_accept[i]) r_buf[i] <= err_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_buf_valid   <= '0;
      r_sel         <= '0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_err_valid   <= 1'b0;
      r_err         <= '0;
      r_ack_timeout <= 1'b0;
    end else begin
      r_err_valid   <= 1'b0;
      r_err         <= '0;
      r_ack_timeout <= 1'b0;
      if (!enable_i) begin
        r_state     <= IDLE;
        r_buf_valid <= '0;
        r_rr_ptr    <= '0;
        r_cnt       <= '0;
      end else begin
        for (int unsigned i = 0; i < N; i++) begin
          if (w_accept[i]) r_buf_valid[i] <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            // Never overwrite a capture that software has not yet cleared.
            if (!capture_ip_i && w_any_gnt) begin
              r_sel       <= w_gnt_idx;
              r_err_valid <= 1'b1;
              r_err       <= r_buf[w_gnt_idx];
              r_state     <= ISSUE;
            end
          end
          ISSUE: begin
            r_buf_valid[r_sel] <= 1'b0;
            r_rr_ptr           <= w_ptr_nxt;
            r_cnt              <= '0;
            r_state            <= WAIT_SET;
          end
          WAIT_SET: begin
            if (capture_ip_i) begin
              r_state <= WAIT_CLR;
            end else begin
              r_cnt <= w_cnt_inc;
              // Capture never acknowledged: drop the record, do not retry.
              if (w_cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                r_ack_timeout <= 1'b1;
                r_state       <= IDLE;
              end
            end
          end
          WAIT_CLR: begin
            if (!capture_ip_i) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_iopmp_err_arbiter.sv
// Directed bench for rv_iopmp_err_arbiter with an in-order record scoreboard.
module tb_rv_iopmp_err_arbiter;
  import rv_iopmp_pkg::*;

  localparam int unsigned N = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     enable;
  logic                     ip;
  logic [N-1:0]             vin;
  logic [N-1:0]             rdy;
  error_capture_t [N-1:0]   din;
  logic                     vout;
  error_capture_t           dout;
  logic                     ack;
  logic [2:0]               pend;

  int             n_pass = 0;
  int             n_tot  = 0;
  error_capture_t sb[$];
  logic           got;

  always #5 clk = ~clk;

  rv_iopmp_err_arbiter #(
    .NUMBER_IOPMP_INSTANCES (N),
    .ACK_TIMEOUT            (15)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .err_valid_i   (vin),
    .err_ready_o   (rdy),
    .err_i         (din),
    .capture_ip_i  (ip),
    .err_valid_o   (vout),
    .err_o         (dout),
    .ack_timeout_o (ack),
    .pending_o     (pend)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic error_capture_t mkrec(input int k);
    error_capture_t r;
    r.ttype = 2'(k);
    r.etype = 3'(k + 1);
    r.rrid  = 16'(k * 7 + 3);
    r.eid   = 16'(k + 256);
    r.addr  = 32'h8000_0000 | 32'(k << 4);
    r.addrh = 32'($urandom);
    return r;
  endfunction

  // Advance one cycle, sample after the edge, and retire any issued record.
  task automatic tick();
    error_capture_t e;
    @(posedge clk);
    #1;
    got = vout;
    if (vout) begin
      chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_record", 128'(dout), 128'(e));
      end
    end
  endtask

  task automatic load(input logic [N-1:0] mask, input logic [N-1:0] push, input int base);
    for (int i = 0; i < int'(N); i++) begin
      if (mask[i]) begin
        din[i] = mkrec(base + i);
        vin[i] = 1'b1;
        if (push[i]) sb.push_back(din[i]);
      end
    end
    chk("load_ready", 128'(rdy & mask), 128'(mask));
    tick();
    vin = '0;
  endtask

  task automatic serve(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = got;
    end
    chk(tag, 128'(seen), 128'(1));
    ip = 1'b1;
    tick();
    tick();
    ip = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    vin    = '0;
    ip     = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  initial begin
    int   k;
    int   nv;
    logic seen;
    rst_n  = 1'b0;
    enable = 1'b1;
    ip     = 1'b0;
    vin    = '0;
    din    = '0;
    got    = 1'b0;
    #1;
    chk("rst_valid", 128'(vout), 128'(0));
    chk("rst_err_o", 128'(dout), 128'(0));
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_pending", 128'(pend), 128'(0));
    chk("rst_ready", 128'(rdy), 128'(4'hF));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single record on instance 2, handshake in cycle 0.
    load(4'b0100, 4'b0100, 0);
    chk("t1_pending_c1", 128'(pend), 128'(1));
    chk("t1_novalid_c1", 128'(vout), 128'(0));
    tick();
    chk("t1_issue_c2", 128'(vout), 128'(1));
    tick();
    chk("t1_strobe_c3", 128'(vout), 128'(0));
    chk("t1_err_zero_c3", 128'(dout), 128'(0));
    tick();
    ip = 1'b1;
    repeat (6) tick();
    chk("t1_wait_clr_c10", 128'(dut.r_state), 128'(WAIT_CLR));
    ip = 1'b0;
    tick();
    chk("t1_idle_c11", 128'(dut.r_state), 128'(IDLE));
    chk("t1_pending_c11", 128'(pend), 128'(0));

    // Round-robin order 0,1,2,3 then 1,3 from rr_ptr=0.
    do_reset();
    ip = 1'b1;
    load(4'hF, 4'hF, 10);
    chk("rr_pending4", 128'(pend), 128'(4));
    chk("rr_ready0", 128'(rdy), 128'(0));
    tick();
    tick();
    chk("rr_hold_ip", 128'(got), 128'(0));
    ip = 1'b0;
    serve("rr_issue0");
    serve("rr_issue1");
    serve("rr_issue2");
    serve("rr_issue3");
    chk("rr_ptr_wrap", 128'(dut.r_rr_ptr), 128'(0));
    load(4'b1010, 4'b1010, 20);
    serve("rr_reissue1");
    serve("rr_reissue3");
    chk("rr_ptr_after3", 128'(dut.r_rr_ptr), 128'(0));

    // Back-pressure on instance 0.
    do_reset();
    ip = 1'b1;
    load(4'b0001, 4'b0001, 30);
    din[0] = mkrec(31);
    vin[0] = 1'b1;
    tick();
    tick();
    chk("bp_ready_low", 128'(rdy[0]), 128'(0));
    chk("bp_pending1", 128'(pend), 128'(1));
    ip = 1'b0;
    tick();
    chk("bp_issue", 128'(vout), 128'(1));
    chk("bp_ready_in_issue", 128'(rdy[0]), 128'(0));
    tick();
    chk("bp_ready_after", 128'(rdy[0]), 128'(1));
    sb.push_back(din[0]);
    tick();
    vin = '0;
    chk("bp_accepted", 128'(pend), 128'(1));
    chk("bp_ready_relow", 128'(rdy[0]), 128'(0));
    ip = 1'b1;
    tick();
    ip = 1'b0;
    tick();
    serve("bp_second");

    // Acknowledge timeout: ip never rises.
    do_reset();
    load(4'b0011, 4'b0011, 40);
    tick();
    chk("to_first_issue", 128'(got), 128'(1));
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      tick();
      k++;
      seen = ack;
    end
    chk("to_latency", 128'(k), 128'(16));
    chk("to_idle", 128'(dut.r_state), 128'(IDLE));
    chk("to_no_valid", 128'(vout), 128'(0));
    tick();
    chk("to_next_issue", 128'(vout), 128'(1));
    chk("to_ack_one_cycle", 128'(ack), 128'(0));

    // Disable while a record is held in WAIT_CLR with three buffers full.
    do_reset();
    load(4'hF, 4'b0001, 50);
    tick();
    chk("dis_issue", 128'(got), 128'(1));
    ip = 1'b1;
    tick();
    tick();
    chk("dis_wait_clr", 128'(dut.r_state), 128'(WAIT_CLR));
    chk("dis_pending3", 128'(pend), 128'(3));
    enable = 1'b0;
    #1;
    chk("dis_ready_low", 128'(rdy), 128'(0));
    tick();
    enable = 1'b1;
    ip     = 1'b0;
    chk("dis_pending0", 128'(pend), 128'(0));
    chk("dis_idle", 128'(dut.r_state), 128'(IDLE));
    nv = 0;
    repeat (10) begin
      tick();
      nv += int'(got);
    end
    chk("dis_no_issue", 128'(nv), 128'(0));

    // Asynchronous reset during ISSUE.
    do_reset();
    load(4'b0010, 4'b0010, 60);
    tick();
    chk("ar_issue", 128'(got), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(vout), 128'(0));
    chk("ar_err_o", 128'(dout), 128'(0));
    chk("ar_ack", 128'(ack), 128'(0));
    chk("ar_pending", 128'(pend), 128'(0));
    chk("ar_ready", 128'(rdy), 128'(4'hF));
    chk("ar_idle", 128'(dut.r_state), 128'(IDLE));
    #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (5) begin
      tick();
      nv += int'(got);
    end
    chk("ar_record_lost", 128'(nv), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rv_iopmp_err_arbiter.md
# rv_iopmp_err_arbiter

Serializes error records from NUMBER_IOPMP_INSTANCES IOPMP checker instances into the single error-capture register set (err_reqinfo/err_reqid/err_reqaddr/err_reqaddrh). Each instance has a one-entry holding buffer. Buffered records are granted round-robin. A record is issued only when the capture register is free (err_reqinfo.ip clear), and is then tracked until software clears ip. It sits between the instance error interfaces and the error-capture logic inside the regmap wrapper.

## Interface
- NUMBER_IOPMP_INSTANCES, 4: number of requesting instances, ≥1.
- ACK_TIMEOUT, 15: cycles to wait for ip to rise after issue; minimum 1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- enable_i  in  1  reg2hw.hwcfg0.enable.q; low flushes the block.
- err_valid_i  in  N  per-instance record valid.
- err_ready_o  out  N  per-instance buffer free.
- err_i  in  N × rv_iopmp_pkg::error_capture_t  per-instance record.
- capture_ip_i  in  1  reg2hw.err_reqinfo.ip.q.
- err_valid_o  out  1  one-cycle issue strobe to capture logic.
- err_o  out  error_capture_t  issued record; '0 when err_valid_o low.
- ack_timeout_o  out  1  one-cycle pulse when WAIT_SET times out.
- pending_o  out  $clog2(N+1)  number of occupied buffers.

## Operation
- Buffer i:
  - buf_valid[i] is set on err_valid_i[i] & err_ready_o[i].
  - It is cleared in the ISSUE cycle for sel.
  - err_ready_o[i] = enable_i & ~buf_valid[i]. There is no bypass.
  - A slot freed in cycle T accepts again in T+1.
- FSM states: IDLE, ISSUE, WAIT_SET, WAIT_CLR.
- IDLE:
  - Condition: capture_ip_i==0 and any buf_valid.
  - Action: register sel = first set buf_valid at or after rr_ptr, wrapping modulo N, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive err_valid_o=1 and err_o=buf[sel].
  - Clear buf_valid[sel].
  - rr_ptr ← sel+1, wrapping N-1→0.
  - Clear the timeout counter and go to WAIT_SET.
- WAIT_SET:
  - capture_ip_i==1 → WAIT_CLR.
  - Otherwise the counter increments; when it reaches ACK_TIMEOUT, pulse ack_timeout_o and go to IDLE. The record is dropped, not retried.
- WAIT_CLR: capture_ip_i==0 → IDLE.
- enable_i==0, any state:
  - Next state IDLE and all buf_valid cleared.
  - rr_ptr and counter reset to 0.
  - err_ready_o stays 0 while enable_i is low.
- Only one record is in flight. A new record never overwrites an unacknowledged capture.
- pending_o = popcount(buf_valid). The counter width is $clog2(ACK_TIMEOUT+1).

## Timing
- Reset values:
  - State IDLE; buf_valid, sel, rr_ptr and counter all 0.
  - err_valid_o=0, err_o='0, ack_timeout_o=0, pending_o=0.
  - err_ready_o follows enable_i: all ones if enable_i is high.
- Minimum latency with capture free: handshake in cycle T, buffer visible in T+1 (IDLE arbitrates), err_valid_o high in T+2.
- Back-to-back records: the second issue occurs no earlier than 2 cycles after capture_ip_i falls (WAIT_CLR→IDLE→ISSUE).
- If err_valid_i and the ISSUE clear for the same slot happen in the same cycle, ready is low, so acceptance happens in the next cycle.
- If capture_ip_i is already high in IDLE, no issue occurs. Buffers hold and back-pressure the instances.
- Asynchronous reset mid-operation returns every register to its reset value immediately. An in-flight record is lost.

## Structure
- rv_iopmp_pkg gains:
  - err_arb_state_e {IDLE, ISSUE, WAIT_SET, WAIT_CLR}.
  - The ACK_TIMEOUT default constant.
- error_capture_t is reused unchanged.
- Sub-module rv_iopmp_rr_arb (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: gnt_idx, any_gnt.
  - Purely combinational, with a rotating-priority search.
- The FSM, buffers and counter live in the top module.

## Test plan
- Single record: N=4, instance 2 valid in cycle 0 with ip=0. err_valid_o is high in cycle 2 with err_o equal to the sent record. Drive ip=1 in cycle 4 and ip=0 in cycle 10: state returns to IDLE in cycle 11 and pending_o=0.
- Round-robin: all four buffers are loaded while ip=1; release ip and ack each issue. Issue order is 0,1,2,3. Then reload 3 and 1: order is 1,3 from rr_ptr=0, and after issuing 3, rr_ptr=0.
- Back-pressure: while instance 0's buffer is full, err_ready_o[0]=0 and a second err_valid_i[0] is held. It is accepted the cycle after ISSUE clears slot 0.
- Timeout: ACK_TIMEOUT=15 and ip is never raised after an issue. ack_timeout_o pulses 16 cycles after err_valid_o, the FSM is in IDLE, and the next buffered record issues 1 cycle later.
- Disable mid-flight: three buffers full, state WAIT_CLR, enable_i dropped for 1 cycle. pending_o=0, state IDLE, err_ready_o=0 that cycle, and no err_valid_o follows.
- Async reset asserted in ISSUE: err_valid_o falls immediately. All outputs read their reset values, with err_ready_o matching enable_i.
